sha_round_sequencer: RTL and testbench
======================================

// Module: sha_round_sequencer
// PURPOSE
//  Parametrised round sequencer for the SHA compression datapath; generalises the
//  plain round index counter with a start/busy/done handshake, stall, abort,
//  round-phase flags and a processed-block counter. It drives the message-schedule
//  mux (W from input block vs. expansion) and the round-constant index, and tells
//  the top FSM when a block's rounds are finished. ROUNDS=64 for SHA-256, 80 for SHA-512.
// PARAMETERS
//  CNT_W       7   width of round index j; must satisfy 2**CNT_W >= ROUNDS
//  ROUNDS      64  rounds per block; legal 2..2**CNT_W
//  SCHED_SPLIT 16  rounds whose W comes straight from the input block; 1..ROUNDS
//  BLK_W       8   width of processed-block counter
// PORTS
//  i_clk        in   1      clock, all state on rising edge
//  i_rst        in   1      asynchronous active-low reset
//  start        in   1      request to run one block; accepted only in IDLE
//  stall        in   1      freeze round advance (RUN only)
//  abort        in   1      terminate current block, return to IDLE
//  clr_blk      in   1      synchronous clear of blk_cnt and blk_ovf
//  j            out  CNT_W  current round index
//  round_vld    out  1      high in RUN: j is a live round
//  first_round  out  1      round_vld && j==0
//  last_round   out  1      round_vld && j==ROUNDS-1
//  sched_sel    out  1      round_vld && j<SCHED_SPLIT (select input word for W)
//  busy         out  1      state != IDLE
//  done         out  1      one-cycle pulse: block's rounds completed
//  blk_cnt      out  BLK_W  completed blocks since reset/clr_blk (wraps)
//  blk_ovf      out  1      sticky: blk_cnt has wrapped
// BEHAVIOUR
//  - Reset (i_rst=0, async): state=IDLE, j=0, blk_cnt=0, blk_ovf=0; every output 0.
//  - All outputs are registers or decoded from registered state/j only (no
//    combinational path from inputs to outputs).
//  - States: IDLE, RUN, DONE.
//    IDLE: j=0. start=1 && abort=0 -> RUN next cycle with j=0.
//    RUN : stall=1 -> j holds, state holds. stall=0 && j<ROUNDS-1 -> j<=j+1.
//          stall=0 && j==ROUNDS-1 -> DONE, j<=0.
//    DONE: done=1 for exactly this one cycle; blk_cnt<=blk_cnt+1; -> IDLE.
//  - Latency: start accepted at edge N -> first_round high cycle N+1; with no
//    stalls last_round at N+ROUNDS, done at N+ROUNDS+1, busy low at N+ROUNDS+2.
//    Each stall cycle in RUN adds exactly one cycle.
//  - start outside IDLE is ignored (not queued). stall outside RUN is ignored.
//  - abort=1 in any state: next state IDLE, j<=0, no done pulse, blk_cnt not
//    incremented (abort in DONE suppresses nothing already visible: done of that
//    cycle still asserted, but the increment is cancelled). abort beats start.
//  - blk_cnt wraps 2**BLK_W-1 -> 0; the wrap sets blk_ovf (sticky).
//  - clr_blk=1: blk_cnt<=0, blk_ovf<=0; wins over a simultaneous DONE increment.
//    clr_blk does not affect state or j.
//  - j never exceeds ROUNDS-1; arithmetic is CNT_W-bit unsigned.
//  - Reset asserted mid-RUN: immediate return to reset values, no done.
// TESTING
//  1 Reset then start=1 one cycle, no stall (ROUNDS=64) -> first_round next
//    cycle, j 0..63, last_round at j=63, done one cycle later, blk_cnt=1.
//  2 stall=1 for 3 cycles at j=10 -> j holds 10 for 3 cycles, done 3 cycles late;
//    sched_sel high exactly for j=0..15.
//  3 abort at j=30 with start also high -> IDLE next cycle, j=0, no done,
//    blk_cnt unchanged; start pulsed while busy -> ignored.
//  4 BLK_W=2: complete 4 blocks -> blk_cnt 1,2,3,0 and blk_ovf=1; clr_blk in same
//    cycle as a DONE -> blk_cnt=0, blk_ovf=0.
//  5 ROUNDS=80, CNT_W=7: run one block -> last_round at j=79, done at N+81.
//  6 i_rst low at j=40 between clock edges -> outputs 0 immediately; after
//    release, IDLE and next start begins at j=0.

Source files
------------

// File: rtl/sha_round_sequencer_if.sv
// Control/status bundle between the SHA top FSM and the round sequencer.
// Master side issues start/stall/abort/clr_blk; slave side reports round state.
// Widths follow the sequencer's round-index and block-counter parameters.
interface sha_round_sequencer_if #(
    parameter int CNT_W = 7,
    parameter int BLK_W = 8
);
    logic             start;
    logic             stall;
    logic             abort;
    logic             clr_blk;
    logic [CNT_W-1:0] j;
    logic             round_vld;
    logic             first_round;
    logic             last_round;
    logic             sched_sel;
    logic             busy;
    logic             done;
    logic [BLK_W-1:0] blk_cnt;
    logic             blk_ovf;

    modport master (
        output start, stall, abort, clr_blk,
        input  j, round_vld, first_round, last_round, sched_sel,
               busy, done, blk_cnt, blk_ovf
    );

    modport slave (
        input  start, stall, abort, clr_blk,
        output j, round_vld, first_round, last_round, sched_sel,
               busy, done, blk_cnt, blk_ovf
    );
endinterface

// File: rtl/sha_round_sequencer.sv
// Round sequencer for the SHA compression datapath: round index, phase flags, block count.
// Latency: start -> first round next cycle; done ROUNDS+1 cycles after start acceptance.
// Backpressure: stall freezes the round index in RUN; abort returns to IDLE from any state.
module sha_round_sequencer #(
    parameter int CNT_W       = 7,
    parameter int ROUNDS      = 64,
    parameter int SCHED_SPLIT = 16,
    parameter int BLK_W       = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    sha_round_sequencer_if.slave   sif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index of the final round; the compare is done at CNT_W bits.
    localparam logic [CNT_W-1:0] LAST_J  = CNT_W'(ROUNDS - 1);
    // One extra bit so SCHED_SPLIT == 2**CNT_W is still representable.
    localparam logic [CNT_W:0]   SPLIT_X = (CNT_W + 1)'(SCHED_SPLIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] j_q, j_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blk_ovf_q, blk_ovf_d;

    logic             in_run;
    logic             blk_inc;

    assign in_run = (state_q == ST_RUN);

    // State, round index and block counter registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            j_q       <= '0;
            blk_cnt_q <= '0;
            blk_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            blk_cnt_q <= blk_cnt_d;
            blk_ovf_q <= blk_ovf_d;
        end
    end

    // Next state and round index; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        unique case (state_q)
            ST_IDLE: begin
                j_d = '0;
                if (sif.start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!sif.stall) begin
                    if (j_q == LAST_J) begin
                        state_d = ST_DONE;
                        j_d     = '0;
                    end else begin
                        j_d = j_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                j_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
                j_d     = '0;
            end
        endcase
        if (sif.abort) begin
            state_d = ST_IDLE;
            j_d     = '0;
        end
    end

    // Completed-block counter; the increment leaves DONE unless aborted, clear wins.
    assign blk_inc = (state_q == ST_DONE) && !sif.abort;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        blk_ovf_d = blk_ovf_q;
        if (sif.clr_blk) begin
            blk_cnt_d = '0;
            blk_ovf_d = 1'b0;
        end else if (blk_inc) begin
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
            if (blk_cnt_q == {BLK_W{1'b1}}) begin
                blk_ovf_d = 1'b1;
            end
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign sif.j           = j_q;
    assign sif.round_vld   = in_run;
    assign sif.first_round = in_run && (j_q == '0);
    assign sif.last_round  = in_run && (j_q == LAST_J);
    assign sif.sched_sel   = in_run && ({1'b0, j_q} < SPLIT_X);
    assign sif.busy        = (state_q != ST_IDLE);
    assign sif.done        = (state_q == ST_DONE);
    assign sif.blk_cnt     = blk_cnt_q;
    assign sif.blk_ovf     = blk_ovf_q;

endmodule

// File: tb/tb_sha_round_sequencer.sv
// Directed bench for sha_round_sequencer: a 64-round/8-bit-count instance and an
// 80-round/2-bit-count instance share clock and reset. Inputs change and outputs
// are sampled on the falling edge, away from the active rising edge.
module tb_sha_round_sequencer;

    logic i_clk;
    logic i_rst;

    int n_chk;
    int n_pass;

    sha_round_sequencer_if #(.CNT_W(7), .BLK_W(8)) ifa ();
    sha_round_sequencer_if #(.CNT_W(7), .BLK_W(2)) ifb ();

    sha_round_sequencer #(
        .CNT_W(7), .ROUNDS(64), .SCHED_SPLIT(16), .BLK_W(8)
    ) dut_a (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .sif   (ifa)
    );

    sha_round_sequencer #(
        .CNT_W(7), .ROUNDS(80), .SCHED_SPLIT(16), .BLK_W(2)
    ) dut_b (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .sif   (ifb)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One block on the 64-round instance, with optional stall run and a start pulse while busy.
    task automatic run_a(input int stall_at, input int stall_len, input int pulse_at,
                         input logic [7:0] exp_blk);
        int exp_j;
        int left;
        exp_j = 0;
        left  = stall_len;
        ifa.start = 1'b1;
        @(negedge i_clk);
        ifa.start = 1'b0;
        for (int g = 0; g < 200; g++) begin
            chk("a_vld",   ifa.round_vld,   1);
            chk("a_busy",  ifa.busy,        1);
            chk("a_done_early", ifa.done,   0);
            chk("a_j",     ifa.j,           exp_j);
            chk("a_first", ifa.first_round, exp_j == 0);
            chk("a_last",  ifa.last_round,  exp_j == 63);
            chk("a_sched", ifa.sched_sel,   exp_j < 16);
            ifa.start = (exp_j == pulse_at);
            if (exp_j == stall_at && left > 0) begin
                ifa.stall = 1'b1;
                left--;
            end else begin
                ifa.stall = 1'b0;
                if (exp_j == 63) break;
                exp_j++;
            end
            @(negedge i_clk);
        end
        ifa.stall = 1'b0;
        ifa.start = 1'b0;
        @(negedge i_clk);
        chk("a_done",      ifa.done,      1);
        chk("a_done_busy", ifa.busy,      1);
        chk("a_done_vld",  ifa.round_vld, 0);
        chk("a_done_j",    ifa.j,         0);
        @(negedge i_clk);
        chk("a_done_pulse", ifa.done,     0);
        chk("a_idle_busy",  ifa.busy,     0);
        chk("a_blk_cnt",    ifa.blk_cnt,  exp_blk);
        @(negedge i_clk);
        chk("a_no_requeue", ifa.busy,     0);
    endtask

    // One block on the 80-round instance; optionally clear the block count during DONE.
    task automatic run_b(input logic clr_at_done, input logic [1:0] exp_blk, input logic exp_ovf);
        ifb.start = 1'b1;
        @(negedge i_clk);
        ifb.start = 1'b0;
        for (int k = 0; k < 80; k++) begin
            chk("b_j",    ifb.j,          k);
            chk("b_last", ifb.last_round, k == 79);
            chk("b_done_early", ifb.done, 0);
            if (k < 79) @(negedge i_clk);
        end
        @(negedge i_clk);
        chk("b_done", ifb.done, 1);
        ifb.clr_blk = clr_at_done;
        @(negedge i_clk);
        ifb.clr_blk = 1'b0;
        chk("b_done_pulse", ifb.done,    0);
        chk("b_idle_busy",  ifb.busy,    0);
        chk("b_blk_cnt",    ifb.blk_cnt, exp_blk);
        chk("b_blk_ovf",    ifb.blk_ovf, exp_ovf);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        i_rst  = 1'b0;
        ifa.start = 1'b0; ifa.stall = 1'b0; ifa.abort = 1'b0; ifa.clr_blk = 1'b0;
        ifb.start = 1'b0; ifb.stall = 1'b0; ifb.abort = 1'b0; ifb.clr_blk = 1'b0;

        // Reset values.
        #3;
        chk("rst_j",     ifa.j,         0);
        chk("rst_vld",   ifa.round_vld, 0);
        chk("rst_busy",  ifa.busy,      0);
        chk("rst_done",  ifa.done,      0);
        chk("rst_sched", ifa.sched_sel, 0);
        chk("rst_blk",   ifa.blk_cnt,   0);
        chk("rst_ovf",   ifa.blk_ovf,   0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("idle_busy", ifa.busy, 0);

        // Plain block.
        run_a(-1, 0, -1, 8'd1);
        // Three stall cycles at j=10 plus a start pulse at j=20 that must be ignored.
        run_a(10, 3, 20, 8'd2);

        // Abort at j=30 with start also high.
        ifa.start = 1'b1;
        @(negedge i_clk);
        ifa.start = 1'b0;
        for (int k = 0; k < 30; k++) @(negedge i_clk);
        chk("ab_j_pre", ifa.j, 30);
        ifa.abort = 1'b1;
        ifa.start = 1'b1;
        @(negedge i_clk);
        ifa.abort = 1'b0;
        ifa.start = 1'b0;
        chk("ab_busy", ifa.busy,      0);
        chk("ab_j",    ifa.j,         0);
        chk("ab_vld",  ifa.round_vld, 0);
        chk("ab_done", ifa.done,      0);
        @(negedge i_clk);
        chk("ab_done2", ifa.done,    0);
        chk("ab_busy2", ifa.busy,    0);
        chk("ab_blk",   ifa.blk_cnt, 2);

        // 80 rounds, 2-bit block counter wrapping.
        run_b(1'b0, 2'd1, 1'b0);
        run_b(1'b0, 2'd2, 1'b0);
        run_b(1'b0, 2'd3, 1'b0);
        run_b(1'b0, 2'd0, 1'b1);
        run_b(1'b1, 2'd0, 1'b0);

        // Asynchronous reset mid-block at j=40.
        ifa.start = 1'b1;
        @(negedge i_clk);
        ifa.start = 1'b0;
        for (int k = 0; k < 40; k++) @(negedge i_clk);
        chk("mr_j_pre", ifa.j, 40);
        #2;
        i_rst = 1'b0;
        #1;
        chk("mr_j",    ifa.j,         0);
        chk("mr_vld",  ifa.round_vld, 0);
        chk("mr_busy", ifa.busy,      0);
        chk("mr_done", ifa.done,      0);
        chk("mr_blk",  ifa.blk_cnt,   0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("mr_idle", ifa.busy, 0);
        chk("mr_nodone", ifa.done, 0);
        ifa.start = 1'b1;
        @(negedge i_clk);
        ifa.start = 1'b0;
        chk("mr_first", ifa.first_round, 1);
        chk("mr_j0",    ifa.j,           0);
        @(negedge i_clk);
        chk("mr_j1",    ifa.j,           1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
